regfile_reader: RTL and testbench
=================================

# regfile_reader

Read-side companion to the team's 20 x 8-bit register file. Takes a snapshot of the register file's flat 160-bit contents bus when a read is requested. Then streams a selected window of bytes out over a valid/ready byte interface, one register per beat, with index and last-beat tags. It sits between the register file and any downstream byte consumer, such as a serializer, debug dump or DMA-style copier.

## Interface
Parameters:
- NUM_REGS, 20, number of 8-bit registers on the contents bus
- DATA_W, 8, bits per register
- IDX_W, 5, width of index/length fields

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  sole clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- all_data  input  NUM_REGS*DATA_W (160)  register contents; register i occupies bits [8i+7:8i]
- start  input  1  read request, sampled only in IDLE
- start_idx  input  IDX_W  first register index to read
- len  input  IDX_W  number of registers to read; 0 means NUM_REGS
- busy  output  1  high in any state other than IDLE
- out_valid  output  1  out_data/out_idx/out_last are valid
- out_ready  input  1  consumer accepts the current beat
- out_data  output  DATA_W  register byte
- out_idx  output  IDX_W  index of the register in out_data
- out_last  output  1  current beat is the final beat of the window
- done  output  1  one-cycle pulse after the final beat transfers
- err  output  1  one-cycle pulse when a start is rejected

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE, start=1, start_idx < NUM_REGS:
  - capture all_data into an internal 160-bit shadow register
  - load cur_idx = start_idx
  - load remaining = effective length
  - go to STREAM
- Effective length: len==0 gives NUM_REGS; len > NUM_REGS is clamped to NUM_REGS.
- IDLE, start=1, start_idx >= NUM_REGS: err=1 for one cycle, state stays IDLE, no beats are produced.
- STREAM:
  - out_valid=1
  - out_data = shadow[cur_idx]
  - out_idx = cur_idx
  - out_last = (remaining==1)
- A beat transfers on any cycle with out_valid & out_ready. On transfer:
  - cur_idx increments, wrapping NUM_REGS-1 to 0
  - remaining decrements
  - if the beat was the last one, go to DONE
- Index arithmetic is modulo NUM_REGS and never produces an index >= NUM_REGS.
- DONE: done=1, out_valid=0, busy=1; go to IDLE on the next cycle.
- start is ignored while in STREAM or DONE; err is not raised for it.
- Changes on all_data after capture do not affect the stream (snapshot semantics).
- Handshake rules:
  - out_valid never depends combinationally on out_ready
  - while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable
  - out_valid never drops before its beat transfers, except on rst
- Reset values: state IDLE; all outputs 0 (busy, out_valid, out_data, out_idx, out_last, done, err); shadow, cur_idx and remaining cleared.
- Reset mid-operation: the stream is abandoned on the next edge, there is no done pulse, and out_valid=0 from the cycle after rst is sampled.

## Timing
- Start accepted at edge T: busy=1 and out_valid=1 with the first byte during cycle T+1.
- With out_ready held high, one beat transfers per cycle. N beats occupy cycles T+1..T+N, out_last=1 in cycle T+N, and done=1 in cycle T+N+1.
- busy returns to 0 in cycle T+N+2, and a new start is accepted at the end of that cycle.
- Each low cycle on out_ready while out_valid=1 adds exactly one cycle of latency.
- err pulses in the cycle after the rejected start is sampled.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use register i = 0x10+i.
- Full dump: start_idx=0, len=0, out_ready=1.
  - Required: 20 beats with bytes 0x10..0x23 and idx 0..19 in cycles T+1..T+20; out_last only on byte 0x23; done in T+21; busy low in T+22.
- Wrap-around: start_idx=18, len=4.
  - Required: bytes 0x22, 0x23, 0x10, 0x11 with idx 18, 19, 0, 1; out_last on 0x11.
- Backpressure: start_idx=5, len=3, out_ready toggling 0,1,0,0,1,1.
  - Required: bytes 0x15, 0x16, 0x17 each held stable until accepted; no beat duplicated or dropped; done pulses once.
- Snapshot and ignored start: start_idx=0, len=2, then write 0xFF to register 1 on all_data and assert start again during STREAM.
  - Required: second beat is 0x11, not 0xFF; no extra stream; err stays 0.
- Rejection and clamp:
  - start_idx=20: err pulse, busy stays 0, no out_valid.
  - start_idx=0, len=25: exactly 20 beats.
- Reset mid-stream: rst=1 for one cycle after the 3rd beat of a full dump.
  - Required: all outputs 0 the next cycle; no done pulse; a fresh start afterwards streams from 0x10 normally.

Source files
------------

// File: rtl/regfile_reader.sv
// regfile_reader: snapshots the flat register file contents bus on a read
// request, then streams a window of registers out one byte per beat over a
// valid/ready interface, tagging each beat with its register index and a
// last-beat flag.
//
// Handshake: a beat transfers on every rising edge where out_valid and
// out_ready are both high. out_valid is a register and never depends on
// out_ready in the same cycle. Once raised, out_valid stays high and
// out_data/out_idx/out_last stay stable until the beat transfers. Only rst
// can withdraw a beat early.
//
// Every output comes straight from a flop. The next value of each output is
// computed in the same combinational process as the next FSM state. This
// way the first beat is already on the bus in the cycle after a start is
// accepted.
module regfile_reader #(
    parameter int NUM_REGS = 20,
    parameter int DATA_W   = 8,
    parameter int IDX_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REGS*DATA_W-1:0]   all_data,
    input  logic                         start,
    input  logic [IDX_W-1:0]             start_idx,
    input  logic [IDX_W-1:0]             len,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         out_last,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   fsm_state
);

    localparam int BUS_W = NUM_REGS * DATA_W;

    // Largest legal index and the clamp value for the window length.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] MAX_LEN  = IDX_W'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Select register idx from a flat contents bus. An out-of-range index
    // reads as zero. In practice that never happens, because indices are
    // kept in range.
    function automatic logic [DATA_W-1:0] pick_reg(
        input logic [BUS_W-1:0] bus,
        input logic [IDX_W-1:0] idx
    );
        logic [DATA_W-1:0] val;
        val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                val = bus[i*DATA_W +: DATA_W];
            end
        end
        return val;
    endfunction

    // Next register index, wrapping from the top register back to 0.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx >= LAST_IDX) begin
            nxt = '0;
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    // Number of beats for a requested length: 0 means a full dump, and
    // anything larger than the register file is clamped to a full dump.
    function automatic logic [IDX_W-1:0] eff_len(input logic [IDX_W-1:0] l);
        logic [IDX_W-1:0] n;
        if ((l == '0) || (l > MAX_LEN)) begin
            n = MAX_LEN;
        end else begin
            n = l;
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [BUS_W-1:0]    shadow_q,    shadow_d;
    logic [IDX_W-1:0]    cur_idx_q,   cur_idx_d;
    logic [IDX_W-1:0]    remaining_q, remaining_d;

    logic                busy_q,      busy_d;
    logic                valid_q,     valid_d;
    logic [DATA_W-1:0]   data_q,      data_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic                last_q,      last_d;
    logic                done_q,      done_d;
    logic                err_q,       err_d;

    // Decoded helper signals.
    logic                start_ok;
    logic                xfer;
    logic [IDX_W-1:0]    req_len;
    logic [IDX_W-1:0]    nxt_idx;

    assign start_ok = (start_idx < MAX_LEN);
    assign xfer     = valid_q & out_ready;
    assign req_len  = eff_len(len);
    assign nxt_idx  = wrap_inc(cur_idx_q);

    // Next-state and next-output logic for the read sequencer.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        cur_idx_d   = cur_idx_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        data_d      = data_q;
        idx_d       = idx_q;
        last_d      = last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                if (start) begin
                    if (start_ok) begin
                        // Take the snapshot and put the first beat on the bus
                        // at once, straight from the live bus. That is the
                        // same byte that the shadow will hold from the next
                        // cycle on.
                        shadow_d    = all_data;
                        cur_idx_d   = start_idx;
                        remaining_d = req_len;
                        state_d     = ST_STREAM;
                        busy_d      = 1'b1;
                        valid_d     = 1'b1;
                        data_d      = pick_reg(all_data, start_idx);
                        idx_d       = start_idx;
                        last_d      = (req_len == IDX_W'(1));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_STREAM: begin
                busy_d = 1'b1;
                if (xfer) begin
                    if (remaining_q == IDX_W'(1)) begin
                        // Final beat accepted: clear the beat and signal done.
                        remaining_d = '0;
                        state_d     = ST_DONE;
                        valid_d     = 1'b0;
                        data_d      = '0;
                        idx_d       = '0;
                        last_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        // Advance to the next register of the window.
                        cur_idx_d   = nxt_idx;
                        remaining_d = remaining_q - IDX_W'(1);
                        valid_d     = 1'b1;
                        data_d      = pick_reg(shadow_q, nxt_idx);
                        idx_d       = nxt_idx;
                        last_d      = (remaining_q == IDX_W'(2));
                    end
                end
            end

            ST_DONE: begin
                // Single cycle that holds the done pulse; busy drops next.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                data_d  = '0;
                idx_d   = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            cur_idx_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cur_idx_q   <= cur_idx_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign done      = done_q;
    assign err       = err_q;
    assign fsm_state = state_q;

    // ------------------------------------------------------------------
    // Interface properties
    // ------------------------------------------------------------------

    // A stalled beat stays on the bus unchanged until it is accepted.
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_idx) && $stable(out_last)));

    // Streamed indices always name a real register.
    a_idx_range: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (out_idx < MAX_LEN));

    // A beat only appears while the block reports itself busy.
    a_valid_busy: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> busy);

    // done and a beat are never presented together.
    a_done_excl: assert property (@(posedge clk) disable iff (rst)
        done |-> !out_valid);

endmodule

// File: tb/tb_regfile_reader.sv
// Directed testbench for regfile_reader: full dump, wrap-around,
// backpressure, snapshot/ignored start, rejection/clamp and mid-stream reset.
module tb_regfile_reader;

    localparam int NUM_REGS = 20;
    localparam int DATA_W   = 8;
    localparam int IDX_W    = 5;

    logic                       clk;
    logic                       rst;
    logic [NUM_REGS*DATA_W-1:0] all_data;
    logic                       start;
    logic [IDX_W-1:0]           start_idx;
    logic [IDX_W-1:0]           len;
    logic                       busy;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [IDX_W-1:0]           out_idx;
    logic                       out_last;
    logic                       done;
    logic                       err;
    logic [1:0]                 fsm_state;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    regfile_reader #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .all_data(all_data), .start(start),
        .start_idx(start_idx), .len(len), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .done(done), .err(err), .fsm_state(fsm_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < NUM_REGS; i++) all_data[i*DATA_W +: DATA_W] = DATA_W'(8'h10 + i);
    endtask

    // Drive a start for exactly one sampling edge; returns in cycle T+1.
    task automatic pulse_start(input int sidx, input int l);
        start_idx = IDX_W'(sidx);
        len       = IDX_W'(l);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++; if (out_idx !== 5'd0)   begin errors++; $display("FAIL reset_idx got %0d want 0", out_idx); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", fsm_state); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_dump();
        out_ready = 1'b1;
        pulse_start(0, 0);
        for (int k = 0; k < NUM_REGS; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid beat %0d got %b want 1", k, out_valid); end
            checks++; if (out_data !== DATA_W'(8'h10 + k)) begin errors++; $display("FAIL full_data beat %0d got %h want %h", k, out_data, 8'h10 + k); end
            checks++; if (out_idx !== IDX_W'(k)) begin errors++; $display("FAIL full_idx beat %0d got %0d want %0d", k, out_idx, k); end
            checks++; if (out_last !== (k == NUM_REGS - 1)) begin errors++; $display("FAIL full_last beat %0d got %b want %b", k, out_last, k == NUM_REGS - 1); end
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL full_busy_done beat %0d got busy %b done %b want 1 0", k, busy, done); end
            tick();
        end
        checks++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL full_done_cycle got done %b valid %b busy %b want 1 0 1", done, out_valid, busy); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL full_idle_cycle got busy %b done %b want 0 0", busy, done); end
    endtask

    task automatic test_wrap();
        int exp_i [4] = '{18, 19, 0, 1};
        out_ready = 1'b1;
        pulse_start(18, 4);
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_idx !== IDX_W'(exp_i[k])) begin
                errors++; $display("FAIL wrap_idx beat %0d got valid %b idx %0d want 1 %0d", k, out_valid, out_idx, exp_i[k]); end
            checks++; if (out_data !== DATA_W'(8'h10 + exp_i[k])) begin
                errors++; $display("FAIL wrap_data beat %0d got %h want %h", k, out_data, 8'h10 + exp_i[k]); end
            checks++; if (out_last !== (k == 3)) begin
                errors++; $display("FAIL wrap_last beat %0d got %b want %b", k, out_last, k == 3); end
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b want 1", done); end
        tick();
    endtask

    task automatic test_backpressure();
        logic seq [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int b;
        int done_cnt;
        b = 0;
        done_cnt = 0;
        exp_q.delete();
        exp_q.push_back(8'h15); exp_q.push_back(8'h16); exp_q.push_back(8'h17);
        out_ready = 1'b0;
        pulse_start(5, 3);
        for (int c = 0; c < 6; c++) begin
            out_ready = seq[c];
            checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                errors++; $display("FAIL bp_data cycle %0d got valid %b data %h want 1 %h", c, out_valid, out_data, exp_q[0]); end
            checks++; if (out_idx !== IDX_W'(5 + b) || out_last !== (b == 2)) begin
                errors++; $display("FAIL bp_tags cycle %0d got idx %0d last %b want %0d %b", c, out_idx, out_last, 5 + b, b == 2); end
            if (seq[c]) begin
                void'(exp_q.pop_front());
                b++;
            end
            tick();
        end
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid got %b want 0", out_valid); end
        for (int c = 0; c < 3; c++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy %b want 0", busy); end
    endtask

    task automatic test_snapshot();
        out_ready = 1'b1;
        pulse_start(0, 2);
        checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL snap_beat0 got %h want 10", out_data); end
        all_data[1*DATA_W +: DATA_W] = 8'hFF;
        start = 1'b1;
        tick();
        checks++; if (out_data !== 8'h11 || out_last !== 1'b1) begin
            errors++; $display("FAIL snap_beat1 got data %h last %b want 11 1", out_data, out_last); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL snap_err_stream got %b want 0", err); end
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL snap_done got done %b err %b want 1 0", done, err); end
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL snap_no_restart got busy %b valid %b err %b want 0 0 0", busy, out_valid, err); end
        fill_pattern();
        tick();
    endtask

    task automatic test_reject_clamp();
        int beats;
        bit seen_done;
        bit last_ok;
        pulse_start(20, 3);
        checks++; if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reject_pulse got err %b busy %b valid %b want 1 0 0", err, busy, out_valid); end
        tick();
        checks++; if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reject_after got err %b busy %b valid %b want 0 0 0", err, busy, out_valid); end

        beats = 0; seen_done = 1'b0; last_ok = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(DATA_W'(8'h10 + i));
        out_ready = 1'b1;
        pulse_start(0, 25);
        for (int c = 0; c < 30 && !seen_done; c++) begin
            if (done === 1'b1) begin
                seen_done = 1'b1;
            end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
                beats++;
                if (exp_q.size() > 0) begin
                    checks++; if (out_data !== exp_q[0]) begin
                        errors++; $display("FAIL clamp_data beat %0d got %h want %h", beats, out_data, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                if (out_last === 1'b1 && out_idx === 5'd19) last_ok = 1'b1;
                tick();
            end else begin
                tick();
            end
        end
        checks++; if (!seen_done) begin errors++; $display("FAIL clamp_timeout got no done want done within 30 cycles"); end
        checks++; if (beats != NUM_REGS) begin errors++; $display("FAIL clamp_beats got %0d want %0d", beats, NUM_REGS); end
        checks++; if (!last_ok) begin errors++; $display("FAIL clamp_last got no last on idx 19 want last on idx 19"); end
        tick();
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        int valid_cnt;
        done_cnt = 0;
        valid_cnt = 0;
        out_ready = 1'b1;
        pulse_start(0, 0);
        tick();
        tick();
        checks++; if (out_data !== 8'h12) begin errors++; $display("FAIL rstmid_beat3 got %h want 12", out_data); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({busy, out_valid, out_last, done, err} !== 5'b0 || out_data !== 8'h00 || out_idx !== 5'd0) begin
            errors++; $display("FAIL rstmid_outputs got busy %b valid %b data %h idx %0d last %b done %b err %b want all 0",
                busy, out_valid, out_data, out_idx, out_last, done, err); end
        for (int c = 0; c < 3; c++) begin
            if (done === 1'b1) done_cnt++;
            if (out_valid === 1'b1) valid_cnt++;
            tick();
        end
        checks++; if (done_cnt != 0 || valid_cnt != 0) begin
            errors++; $display("FAIL rstmid_quiet got done %0d valid %0d cycles want 0 0", done_cnt, valid_cnt); end
        pulse_start(0, 0);
        for (int k = 0; k < NUM_REGS; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(8'h10 + k)) begin
                errors++; $display("FAIL rstmid_restart beat %0d got valid %b data %h want 1 %h", k, out_valid, out_data, 8'h10 + k); end
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b want 1", done); end
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start_idx = '0;
        len = '0;
        out_ready = 1'b0;
        fill_pattern();
        test_reset();
        test_full_dump();
        test_wrap();
        test_backpressure();
        test_snapshot();
        test_reject_clamp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
